serial_subtractor: RTL and testbench

- Bit-serial multi-bit subtractor built around a single full-subtractor cell with a registered borrow.
- Computes diff = a - b - bin, one bit per clock, LSB first.
- Sits downstream of operand registers in the arithmetic datapath, where area matters more than latency.
- Start/busy/done handshake; result and final borrow are held until the next operation completes.

---
 rtl/serial_subtractor_if.sv | 7 +
 rtl/serial_subtractor.sv | 56 +++++
 tb/tb_serial_subtractor.sv | 121 ++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: start/busy/done handshake and operand/result bus for serial_subtractor
interface serial_subtractor_if #(parameter int WIDTH = 8);
  logic start, bin, busy, done, bout;
  logic [WIDTH-1:0] a, b, diff;
  modport master(output start, a, b, bin, input busy, done, diff, bout);
  modport slave(input start, a, b, bin, output busy, done, diff, bout);
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - bin, one full-subtractor cell, LSB first
module serial_subtractor #(parameter int WIDTH = 8) (
  input logic clk,
  input logic rst,
  serial_subtractor_if.slave s
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] sa, sb, pr, diff_q;
  logic [CW-1:0] cnt;
  logic br, bout_q, d, bn, last;
  assign d = sa[0] ^ sb[0] ^ br;
  assign bn = (~sa[0] & sb[0]) | (sb[0] & br) | (~sa[0] & br);
  assign last = cnt == CW'(WIDTH - 1);
  assign s.busy = state_q != IDLE;
  assign s.done = state_q == DONE;
  assign s.diff = diff_q;
  assign s.bout = bout_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    state_d = (state_q == IDLE && s.start) ? RUN :
              (state_q == RUN && last) ? DONE :
              (state_q == DONE) ? IDLE : state_q;
  end
  // diff/bout load only on the final bit so partial results never appear
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sa <= '0;
      sb <= '0;
      pr <= '0;
      br <= 1'b0;
      cnt <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
    end else if (state_q == IDLE && s.start) begin
      sa <= s.a;
      sb <= s.b;
      br <= s.bin;
      cnt <= '0;
      pr <= '0;
    end else if (state_q == RUN) begin
      pr <= {d, pr[WIDTH-1:1]};
      sa <= sa >> 1;
      sb <= sb >> 1;
      br <= bn;
      cnt <= cnt + CW'(1);
      if (last) begin
        diff_q <= {d, pr[WIDTH-1:1]};
        bout_q <= bn;
      end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: randomized and directed checks of serial_subtractor against arithmetic model
module tb_serial_subtractor;
  logic clk = 1'b0, rst;
  int errs = 0, checks = 0;
  logic [7:0] m_diff;
  logic m_bout;
  serial_subtractor_if #(.WIDTH(8)) i8();
  serial_subtractor_if #(.WIDTH(2)) i2();
  serial_subtractor #(.WIDTH(8)) u8(.clk(clk), .rst(rst), .s(i8));
  serial_subtractor #(.WIDTH(2)) u2(.clk(clk), .rst(rst), .s(i2));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bi, input bit scr);
    logic [8:0] exp;
    int k, nb;
    exp = {1'b0, a} - {1'b0, b} - 9'(bi);
    @(negedge clk);
    i8.start = 1'b1; i8.a = a; i8.b = b; i8.bin = bi;
    @(negedge clk);
    i8.start = 1'b0;
    nb = int'(i8.busy);
    for (k = 1; k <= 20; k++) begin
      if (scr && k < 7) begin
        i8.a = 8'($urandom); i8.b = 8'($urandom); i8.bin = 1'($urandom); i8.start = 1'($urandom);
      end else i8.start = 1'b0;
      @(negedge clk);
      nb += int'(i8.busy);
      if (i8.done) break;
      chk("hold", {i8.bout, i8.diff}, {m_bout, m_diff});
    end
    chk("latency", k, 8);
    chk("diff", i8.diff, exp[7:0]);
    chk("bout", i8.bout, exp[8]);
    m_diff = exp[7:0];
    m_bout = exp[8];
    @(negedge clk);
    nb += int'(i8.busy);
    chk("done_pulse", i8.done, 0);
    chk("busy_cycles", nb, 9);
    if (scr) begin
      for (int j = 0; j < 12; j++) begin
        @(negedge clk);
        chk("no_extra", i8.busy, 0);
      end
    end
  endtask
  task automatic op2(input logic [1:0] a, input logic [1:0] b, input logic bi);
    logic [2:0] exp;
    int k;
    exp = {1'b0, a} - {1'b0, b} - 3'(bi);
    @(negedge clk);
    i2.start = 1'b1; i2.a = a; i2.b = b; i2.bin = bi;
    @(negedge clk);
    i2.start = 1'b0;
    for (k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (i2.done) break;
    end
    chk("w2_latency", k, 2);
    chk("w2_result", {i2.bout, i2.diff}, exp);
    @(negedge clk);
  endtask
  initial begin
    int e;
    int dn;
    rst = 1'b1;
    i8.start = 0; i8.a = 0; i8.b = 0; i8.bin = 0;
    i2.start = 0; i2.a = 0; i2.b = 0; i2.bin = 0;
    m_diff = '0; m_bout = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", i8.busy, 0);
    chk("rst_done", i8.done, 0);
    chk("rst_out", {i8.bout, i8.diff}, 0);
    rst = 1'b0;
    op8(8'h05, 8'h03, 1'b0, 0);
    op8(8'h03, 8'h05, 1'b0, 0);
    op8(8'h00, 8'h00, 1'b1, 0);
    op8(8'hFF, 8'hFF, 1'b1, 0);
    op8(8'hA7, 8'h3C, 1'b1, 1);
    for (int i = 0; i < 30; i++)
      op8(8'($urandom), 8'($urandom), 1'($urandom), bit'($urandom_range(0, 3) == 0));
    @(negedge clk);
    i8.start = 1'b1; i8.a = 8'h10; i8.b = 8'h01; i8.bin = 1'b0;
    dn = 0;
    for (e = 0; e < 30; e++) begin
      @(negedge clk);
      if (i8.done) begin
        chk("held_edge", e, 8 + 10 * dn);
        chk("held_diff", i8.diff, 8'h0F);
        dn++;
      end
    end
    i8.start = 1'b0;
    chk("held_count", dn, 3);
    m_diff = 8'h0F; m_bout = 1'b0;
    @(negedge clk);
    @(negedge clk);
    i8.start = 1'b1; i8.a = 8'h22; i8.b = 8'h11; i8.bin = 1'b0;
    @(posedge clk);
    #1 i8.start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_busy", i8.busy, 0);
    chk("abort_done", i8.done, 0);
    chk("abort_out", {i8.bout, i8.diff}, 0);
    @(negedge clk);
    rst = 1'b0;
    m_diff = '0; m_bout = 1'b0;
    op8(8'h40, 8'h41, 1'b0, 0);
    for (int v = 0; v < 32; v++) op2(2'(v >> 3), 2'(v >> 1), 1'(v));
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
